fft_reorder_buffer: RTL and testbench
=====================================

# fft_reorder_buffer

Self-sequenced ping-pong reorder buffer at the output of the SDF FFT pipeline. It converts the bit-reversed sample stream from the last butterfly stage into natural order, or passes it through in arrival order. The write and read address sequencing, bank swapping, framing and valid signalling are all generated internally, so the block needs no external enable bus or read-select inputs.

## Interface
- LOG_L_FFT, 7, log2 of frame length L (L = 2^LOG_L_FFT).
- B_RE, 41, width of one real/imag component; a sample is 2*B_RE bits, real part in the upper half.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset; asynchronous, active-high.
- in  in  2*B_RE  input sample.
- in_valid  in  1  sample qualifier; at most one sample per cycle; no backpressure.
- in_sof  in  1  start of frame; meaningful only when in_valid=1.
- mode_bitrev  in  1  1 selects bit-reversed read addressing (reorder); 0 selects natural addressing (pass-through order).
- out  out  2*B_RE  output sample, registered.
- out_valid  out  1  output qualifier.
- out_sof  out  1  high with the first sample of each output frame.
- sof_err  out  1  sticky flag; set when in_sof arrives while the write counter is not 0.

## Operation
- Storage: two banks of L x 2*B_RE. The banks are not reset, so they can be inferred as RAM.
- Writer state: wr_bank (1 bit), wr_cnt (LOG_L_FFT bits), full[1:0].
- Writer on in_valid:
  - Effective address is 0 if in_sof=1, otherwise wr_cnt. The sample is written to bank wr_bank at that address.
  - wr_cnt becomes address+1, modulo L.
- Resync: in_valid & in_sof with wr_cnt≠0 sets sof_err. The partial frame is discarded (no full flag is set) and writing restarts at address 0 in the same bank.
- Frame completion: a write to address L-1 sets full[wr_bank], toggles wr_bank and wraps wr_cnt to 0.
- Reader FSM states:
  - IDLE: if full[rd_bank]=1, go to READ. On entry set rd_cnt=0, latch mode_bitrev into mode_q, and clear full[rd_bank].
  - READ: each cycle, out <= bank[rd_bank][addr], with addr = mode_q ? bitrev(rd_cnt) : rd_cnt. Assert out_valid=1, and out_sof=1 when rd_cnt=0. Increment rd_cnt.
  - At rd_cnt=L-1: toggle rd_bank. If full[new rd_bank]=1, stay in READ for the next frame (rd_cnt=0, relatch mode, clear full) with no gap. Otherwise go to IDLE.
- bitrev reverses all LOG_L_FFT bits. For L=128, index 1 maps to 64.
- Set and clear of the same full bit on the same edge cannot occur by construction. If it did, set wins.
- Input rate ≤ 1 sample/cycle guarantees the reader finishes a bank before the writer reenters it, so no overflow handling is required.
- mode_bitrev changes take effect only at the next read-frame start; a frame is never mixed-mode.

## Timing
- Reset values: out=0, out_valid=0, out_sof=0, sof_err=0, wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, full=00, FSM=IDLE.
- Latency: if the last sample of a frame is written at edge E0, full is set at E0. The first output sample is registered at E0+1, so out_valid is high in the cycle after E0+1. The frame ends with out_valid high after E0+L.
- Output is a contiguous burst of L valid cycles per frame, independent of input gaps.
- Back-to-back input frames (in_valid held at 1) produce continuous out_valid with no bubbles. out_sof occurs every L cycles.
- out and out_sof hold their last values while out_valid=0. out_sof is 0 whenever out_valid=0.
- rst asserted mid-operation:
  - Outputs clear immediately, and all partially written or partially read frames are dropped.
  - After release, the first in_valid writes address 0 of bank 0, regardless of in_sof.
- sof_err clears only on rst.

## Test plan
- Single frame, L=128, mode_bitrev=1, in = sample index, contiguous -> out sequence 0,64,32,96,16,80,... with out_valid high 128 cycles, first valid sample 2 edges after the last input, out_sof only on value 0.
- Four back-to-back frames, in = frame*256+index -> 512 consecutive valid outputs, no gaps, out_sof at cycles 0,128,256,384, each frame correctly bit-reversed.
- Input valid on every third cycle, mode_bitrev=0 -> natural-order 128-cycle bursts, 0..127, contiguous output per frame.
- Toggle mode_bitrev during readout of frame 1 (1→0) -> frame 1 stays bit-reversed, frame 2 is natural.
- in_sof at index 50 of frame 1, then 128 clean samples -> sof_err=1, only one output frame (the clean one), bank alignment correct for a following frame.
- rst pulse at output sample 60 of a frame -> out_valid=0 and out=0 immediately. The next full input frame is output correctly 2 edges after its last sample.

Source files
------------

// File: rtl/fft_reorder_if.sv
// Sample stream bundle for the FFT output reorder buffer.
// The master drives the input stream; the slave (the buffer) drives the output stream.
interface fft_reorder_if #(
    parameter int LOG_L_FFT = 7,
    parameter int B_RE      = 41
);
    logic [2*B_RE-1:0] in;
    logic              in_valid;
    logic              in_sof;
    logic              mode_bitrev;
    logic [2*B_RE-1:0] out;
    logic              out_valid;
    logic              out_sof;
    logic              sof_err;

    modport master (
        output in, in_valid, in_sof, mode_bitrev,
        input  out, out_valid, out_sof, sof_err
    );

    modport slave (
        input  in, in_valid, in_sof, mode_bitrev,
        output out, out_valid, out_sof, sof_err
    );
endinterface

// File: rtl/fft_reorder_buffer.sv
// Ping-pong reorder buffer: bit-reversed SDF FFT output to natural order (or pass-through).
// Writer fills one bank while the reader drains the other as a contiguous L-cycle burst.
module fft_reorder_buffer #(
    parameter int LOG_L_FFT = 7,
    parameter int B_RE      = 41
) (
    input  logic        clk,
    input  logic        rst,
    fft_reorder_if.slave bus
);
    localparam int L = 1 << LOG_L_FFT;
    localparam int W = 2 * B_RE;

    typedef logic [LOG_L_FFT-1:0] idx_t;
    localparam idx_t LAST = idx_t'(L - 1);

    typedef enum logic {IDLE, READ} state_t;

    logic [W-1:0] mem_q [2*L];

    logic         wr_bank_q;
    idx_t         wr_cnt_q;
    logic [1:0]   full_q;
    logic [1:0]   full_d;
    logic         sof_err_q;

    state_t       state_q;
    logic         rd_bank_q;
    idx_t         rd_cnt_q;
    logic         mode_q;
    logic [W-1:0] out_q;
    logic         out_valid_q;
    logic         out_sof_q;

    idx_t         wr_addr;
    logic         wr_last;
    logic         resync;
    idx_t         rd_addr;
    logic         rd_start;
    logic         rd_chain;

    function automatic idx_t bitrev(idx_t a);
        idx_t r;
        for (int i = 0; i < LOG_L_FFT; i++) begin
            r[i] = a[LOG_L_FFT-1-i];
        end
        return r;
    endfunction

    always_comb begin
        wr_addr  = bus.in_sof ? '0 : wr_cnt_q;
        wr_last  = bus.in_valid && (wr_addr == LAST);
        resync   = bus.in_valid && bus.in_sof && (wr_cnt_q != '0);
        rd_addr  = mode_q ? bitrev(rd_cnt_q) : rd_cnt_q;
        rd_start = (state_q == IDLE) && full_q[rd_bank_q];
        rd_chain = (state_q == READ) && (rd_cnt_q == LAST)
                   && full_q[~rd_bank_q];
        full_d = full_q;
        if (rd_start) full_d[rd_bank_q] = 1'b0;
        if (rd_chain) full_d[~rd_bank_q] = 1'b0;
        // a completing write takes priority over a reader clear
        if (wr_last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (bus.in_valid) begin
            mem_q[{wr_bank_q, wr_addr}] <= bus.in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            sof_err_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (resync) sof_err_q <= 1'b1;
            if (bus.in_valid) begin
                wr_cnt_q <= wr_addr + 1'b1;
                if (wr_last) wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // IDLE emits sample 0 on the same edge it starts, so the first
    // output lands one edge after the frame's last write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            mode_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        out_q       <= mem_q[{rd_bank_q, idx_t'(0)}];
                        out_valid_q <= 1'b1;
                        out_sof_q   <= 1'b1;
                        rd_cnt_q    <= idx_t'(1);
                        mode_q      <= bus.mode_bitrev;
                        state_q     <= READ;
                    end else begin
                        out_valid_q <= 1'b0;
                        out_sof_q   <= 1'b0;
                    end
                end
                READ: begin
                    out_q       <= mem_q[{rd_bank_q, rd_addr}];
                    out_valid_q <= 1'b1;
                    out_sof_q   <= (rd_cnt_q == '0);
                    rd_cnt_q    <= rd_cnt_q + 1'b1;
                    if (rd_cnt_q == LAST) begin
                        rd_bank_q <= ~rd_bank_q;
                        if (full_q[~rd_bank_q]) begin
                            mode_q <= bus.mode_bitrev;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.sof_err   = sof_err_q;
endmodule

// File: tb/tb_fft_reorder_buffer.sv
// Directed bench for fft_reorder_buffer: ordering, framing, latency,
// resync and reset behaviour with a monitor-fed output queue.
module tb_fft_reorder_buffer;
    localparam int LG = 7;
    localparam int BR = 41;
    localparam int L  = 128;
    localparam int W  = 82;

    typedef struct {
        logic [W-1:0] d;
        logic         sof;
        int           cyc;
    } obs_t;

    typedef struct {
        bit mode;
        int gap;
        int nfr;
        int base;
    } scen_t;

    typedef struct {
        int k;
        int v;
    } spot_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_e0 = 0;
    int   e0f;
    obs_t q[$];

    fft_reorder_if #(.LOG_L_FFT(LG), .B_RE(BR)) bus ();

    fft_reorder_buffer #(.LOG_L_FFT(LG), .B_RE(BR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(int v);
        logic [BR-1:0] r;
        r = BR'(v);
        return {r, r ^ BR'('h155)};
    endfunction

    function automatic int br(int k);
        int r;
        r = 0;
        for (int i = 0; i < LG; i++) begin
            if (k[i]) r |= 1 << (LG - 1 - i);
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [W-1:0] a, logic [W-1:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1)
            q.push_back('{bus.out, bus.out_sof, cyc});
        else if (!rst)
            chk("sof while idle", W'(bus.out_sof), '0);
    end

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic send_frame(int base, int gap, bit sof, int n, int clr_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in       = mk(base + i);
            bus.in_valid = 1'b1;
            bus.in_sof   = sof && (i == 0);
            if (i == clr_at) bus.mode_bitrev = 1'b0;
            if (i == n - 1) last_e0 = cyc + 1;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_sof   = 1'b0;
            end
        end
    endtask

    task automatic wait_q(string nm, int n, int budget);
        int t;
        t = 0;
        while (q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({nm, " timeout"}, W'(q.size() >= n), W'(1));
    endtask

    task automatic check_burst(string nm, int nfr, int base0, int fstep,
                               bit m0, bit mr, bit contig_all);
        logic [W-1:0] e;
        e = '0;
        chk({nm, " count"}, W'(q.size()), W'(nfr * L));
        if (q.size() < nfr * L) return;
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < L; k++) begin
                int  idx;
                bit  m;
                idx = f * L + k;
                m   = (f == 0) ? m0 : mr;
                e   = mk(base0 + f * fstep + (m ? br(k) : k));
                chk($sformatf("%s data[%0d]", nm, idx), q[idx].d, e);
                chk($sformatf("%s sof[%0d]", nm, idx),
                    W'(q[idx].sof), W'(k == 0));
                if (idx > 0 && (contig_all || k != 0))
                    chk($sformatf("%s gap[%0d]", nm, idx),
                        W'(q[idx].cyc), W'(q[idx-1].cyc + 1));
            end
        end
        chk({nm, " hold"}, bus.out, e);
    endtask

    scen_t tab[3];
    spot_t spot[8];

    initial begin
        tab[0] = '{1'b1, 0, 1, 'h0000};
        tab[1] = '{1'b1, 0, 4, 'h1000};
        tab[2] = '{1'b0, 2, 1, 'h2000};
        spot[0] = '{0, 0};
        spot[1] = '{1, 64};
        spot[2] = '{2, 32};
        spot[3] = '{3, 96};
        spot[4] = '{4, 16};
        spot[5] = '{5, 80};
        spot[6] = '{126, 63};
        spot[7] = '{127, 127};

        bus.in          = '0;
        bus.in_valid    = 1'b0;
        bus.in_sof      = 1'b0;
        bus.mode_bitrev = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out", bus.out, '0);
        chk("reset out_valid", W'(bus.out_valid), '0);
        chk("reset out_sof", W'(bus.out_sof), '0);
        chk("reset sof_err", W'(bus.sof_err), '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int s = 0; s < 3; s++) begin
            string nm;
            nm = $sformatf("scen%0d", s);
            bus.mode_bitrev = tab[s].mode;
            q.delete();
            for (int f = 0; f < tab[s].nfr; f++) begin
                send_frame(tab[s].base + f * 256, tab[s].gap, 1'b1, L, -1);
                if (f == 0) e0f = last_e0;
            end
            idle();
            wait_q(nm, tab[s].nfr * L, tab[s].nfr * L + L + 50);
            repeat (10) @(negedge clk);
            check_burst(nm, tab[s].nfr, tab[s].base, 256,
                        tab[s].mode, tab[s].mode, tab[s].gap == 0);
            if (q.size() > 0)
                chk({nm, " latency"}, W'(q[0].cyc), W'(e0f + 1));
            if (s == 0 && q.size() >= L) begin
                for (int j = 0; j < 8; j++)
                    chk($sformatf("spot k=%0d", spot[j].k),
                        q[spot[j].k].d, mk(spot[j].v));
            end
        end

        // mode drops to natural while frame 1 is being read out
        bus.mode_bitrev = 1'b1;
        q.delete();
        send_frame('h5000, 0, 1'b1, L, -1);
        send_frame('h5100, 0, 1'b1, L, 10);
        idle();
        wait_q("mode", 2 * L, 3 * L + 50);
        repeat (10) @(negedge clk);
        check_burst("mode", 2, 'h5000, 'h100, 1'b1, 1'b0, 1'b1);

        // resync: partial frame of 50 then two clean frames
        bus.mode_bitrev = 1'b0;
        q.delete();
        chk("sof_err pre", W'(bus.sof_err), '0);
        send_frame('h6000, 0, 1'b1, 50, -1);
        send_frame('h7000, 0, 1'b1, L, -1);
        send_frame('h7100, 0, 1'b1, L, -1);
        idle();
        wait_q("resync", 2 * L, 3 * L + 100);
        repeat (10) @(negedge clk);
        check_burst("resync", 2, 'h7000, 'h100, 1'b0, 1'b0, 1'b1);
        chk("sof_err set", W'(bus.sof_err), W'(1));

        // reset mid-read with a partial second frame in flight
        bus.mode_bitrev = 1'b1;
        q.delete();
        send_frame('h9000, 0, 1'b1, L, -1);
        send_frame('h9800, 0, 1'b1, 40, -1);
        idle();
        wait_q("rst pre", 60, 200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst out_valid", W'(bus.out_valid), '0);
        chk("rst out", bus.out, '0);
        chk("rst out_sof", W'(bus.out_sof), '0);
        chk("rst sof_err", W'(bus.sof_err), '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        q.delete();
        send_frame('hA000, 0, 1'b0, L, -1);
        e0f = last_e0;
        idle();
        wait_q("post rst", L, 2 * L + 50);
        repeat (20) @(negedge clk);
        check_burst("post rst", 1, 'hA000, 0, 1'b1, 1'b1, 1'b1);
        if (q.size() > 0)
            chk("post rst latency", W'(q[0].cyc), W'(e0f + 1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
